motion_bbox_extract: RTL and testbench

//   Consumes the dilated 1-bit motion mask (downstream of the dilation stage) and

---
 rtl/motion_bbox_extract.sv | 149 ++++++++++++++
 tb/tb_motion_bbox_extract.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motion_bbox_extract.sv
// rtl/motion_bbox_extract.sv - bounding box, pixel count and found flag of a 1-bit motion mask per frame
//
// Ports:
//   clk, rst_n         pixel clock; asynchronous active-low reset
//   dilation_vsync     frame valid (high for the whole active frame)
//   dilation_href      line valid (high for the whole active line)
//   dilation_clken     pixel strobe qualifying dilation_img_Bit
//   dilation_img_Bit   mask pixel, 1 = motion
//   box_x_min/x_max    leftmost / rightmost foreground column of the last frame
//   box_y_min/y_max    top / bottom foreground row of the last frame
//   box_pix_cnt        foreground pixel count of the last frame (saturating)
//   box_found          box_pix_cnt >= MIN_PIXELS; coordinates are 0 when clear
//   box_done           one-cycle pulse in the cycle the outputs change
module motion_bbox_extract #(
    parameter logic [9:0]  IMG_HDISP  = 10'd640,
    parameter logic [9:0]  IMG_VDISP  = 10'd480,
    parameter logic [18:0] MIN_PIXELS = 19'd64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dilation_vsync,
    input  logic        dilation_href,
    input  logic        dilation_clken,
    input  logic        dilation_img_Bit,
    output logic [9:0]  box_x_min,
    output logic [9:0]  box_x_max,
    output logic [9:0]  box_y_min,
    output logic [9:0]  box_y_max,
    output logic [18:0] box_pix_cnt,
    output logic        box_found,
    output logic        box_done
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_PUBLISH = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic        vsync_d, href_d;
    logic        vs_rise, vs_fall, href_fall;
    logic [9:0]  x_cnt, y_cnt, y_cur;
    logic [9:0]  acc_x_min, acc_x_max, acc_y_min, acc_y_max;
    logic [18:0] acc_cnt;
    logic        hit, acc_found;

    assign vs_rise   = dilation_vsync & ~vsync_d;
    assign vs_fall   = ~dilation_vsync & vsync_d;
    assign href_fall = ~dilation_href & href_d;

    // y_cnt is only cleared at the end of the rise cycle, so a pixel arriving
    // in that very cycle belongs to row 0.
    assign y_cur = vs_rise ? 10'd0 : y_cnt;

    assign hit = ((state == ST_ACTIVE) || vs_rise) && dilation_vsync &&
                 dilation_href && dilation_clken && dilation_img_Bit &&
                 (x_cnt < IMG_HDISP) && (y_cur < IMG_VDISP);

    assign acc_found = (acc_cnt >= MIN_PIXELS);

    // vsync_d resets high so that a frame already in progress when reset is
    // released is not mistaken for a rising edge; it is discarded instead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            vsync_d <= 1'b1;
            href_d  <= 1'b0;
        end else begin
            state   <= state_nxt;
            vsync_d <= dilation_vsync;
            href_d  <= dilation_href;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (vs_rise) state_nxt = ST_ACTIVE;
            ST_ACTIVE:  if (vs_fall) state_nxt = ST_PUBLISH;
            ST_PUBLISH: state_nxt = vs_rise ? ST_ACTIVE : ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Pixel/line position trackers run regardless of frame state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt <= 10'd0;
            y_cnt <= 10'd0;
        end else begin
            if (href_fall)
                x_cnt <= 10'd0;
            else if (dilation_href && dilation_clken && (x_cnt != 10'h3FF))
                x_cnt <= x_cnt + 10'd1;

            if (vs_rise)
                y_cnt <= 10'd0;
            else if (href_fall && (y_cnt != 10'h3FF))
                y_cnt <= y_cnt + 10'd1;
        end
    end

    // Accumulators: re-initialised on vsync rise, folding in a same-cycle hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_x_min <= 10'd0;
            acc_x_max <= 10'd0;
            acc_y_min <= 10'd0;
            acc_y_max <= 10'd0;
            acc_cnt   <= 19'd0;
        end else if (vs_rise) begin
            acc_x_min <= hit ? x_cnt : 10'h3FF;
            acc_x_max <= hit ? x_cnt : 10'd0;
            acc_y_min <= hit ? y_cur : 10'h3FF;
            acc_y_max <= hit ? y_cur : 10'd0;
            acc_cnt   <= hit ? 19'd1 : 19'd0;
        end else if (hit) begin
            if (x_cnt < acc_x_min) acc_x_min <= x_cnt;
            if (x_cnt > acc_x_max) acc_x_max <= x_cnt;
            if (y_cur < acc_y_min) acc_y_min <= y_cur;
            if (y_cur > acc_y_max) acc_y_max <= y_cur;
            if (acc_cnt != 19'h7FFFF) acc_cnt <= acc_cnt + 19'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            box_x_min   <= 10'd0;
            box_x_max   <= 10'd0;
            box_y_min   <= 10'd0;
            box_y_max   <= 10'd0;
            box_pix_cnt <= 19'd0;
            box_found   <= 1'b0;
            box_done    <= 1'b0;
        end else begin
            box_done <= (state == ST_PUBLISH);
            if (state == ST_PUBLISH) begin
                box_pix_cnt <= acc_cnt;
                box_found   <= acc_found;
                box_x_min   <= acc_found ? acc_x_min : 10'd0;
                box_x_max   <= acc_found ? acc_x_max : 10'd0;
                box_y_min   <= acc_found ? acc_y_min : 10'd0;
                box_y_max   <= acc_found ? acc_y_max : 10'd0;
            end
        end
    end

endmodule

// File: tb/tb_motion_bbox_extract.sv
// tb/tb_motion_bbox_extract.sv - randomized frame stimulus against a pixel-list bounding box model
module tb_motion_bbox_extract;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic vsync = 1'b0, href = 1'b0, clken = 1'b0, bit_in = 1'b0;

    logic [9:0]  a_x_min, a_x_max, a_y_min, a_y_max;
    logic [18:0] a_cnt;
    logic        a_found, a_done;
    logic [9:0]  b_x_min, b_x_max, b_y_min, b_y_max;
    logic [18:0] b_cnt;
    logic        b_found, b_done;

    always #5 clk = ~clk;

    // a: MIN_PIXELS = 64, b: MIN_PIXELS = 1; both see identical stimulus
    motion_bbox_extract #(.MIN_PIXELS(19'd64)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .dilation_vsync(vsync), .dilation_href(href),
        .dilation_clken(clken), .dilation_img_Bit(bit_in),
        .box_x_min(a_x_min), .box_x_max(a_x_max),
        .box_y_min(a_y_min), .box_y_max(a_y_max),
        .box_pix_cnt(a_cnt), .box_found(a_found), .box_done(a_done)
    );

    motion_bbox_extract #(.MIN_PIXELS(19'd1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .dilation_vsync(vsync), .dilation_href(href),
        .dilation_clken(clken), .dilation_img_Bit(bit_in),
        .box_x_min(b_x_min), .box_x_max(b_x_max),
        .box_y_min(b_y_min), .box_y_max(b_y_max),
        .box_pix_cnt(b_cnt), .box_found(b_found), .box_done(b_done)
    );

    typedef struct packed {
        logic [9:0]  x_min;
        logic [9:0]  x_max;
        logic [9:0]  y_min;
        logic [9:0]  y_max;
        logic [18:0] cnt;
        logic        found;
    } box_t;

    typedef struct {
        int   cyc;
        box_t b64;
        box_t b1;
        logic done1;
    } res_t;

    res_t res_q[$];
    int   cyc = 0;
    int   stray = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    bit   ones[int];          // foreground pixels, key = y*1024 + x
    int   line_len[0:1023];   // clken pixels sent on each line
    int   nlines;
    int   fall_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (a_done)
            res_q.push_back('{cyc, {a_x_min, a_x_max, a_y_min, a_y_max, a_cnt, a_found},
                                   {b_x_min, b_x_max, b_y_min, b_y_max, b_cnt, b_found}, b_done});
        if (b_done && !a_done)
            stray <= stray + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_frame();
        ones.delete();
        foreach (line_len[i]) line_len[i] = 0;
        nlines = 0;
    endtask

    // Reference: every foreground pixel actually sent inside the active area.
    function automatic box_t model(input int min_pix);
        box_t b;
        int xl = 1023, xh = 0, yl = 1023, yh = 0, c = 0;
        foreach (ones[k]) begin
            int x, y;
            x = k % 1024;
            y = k / 1024;
            if (y < nlines && x < line_len[y] && x < 640 && y < 480) begin
                c++;
                if (x < xl) xl = x;
                if (x > xh) xh = x;
                if (y < yl) yl = y;
                if (y > yh) yh = y;
            end
        end
        b.cnt   = 19'(c);
        b.found = (c >= min_pix);
        b.x_min = b.found ? 10'(xl) : 10'd0;
        b.x_max = b.found ? 10'(xh) : 10'd0;
        b.y_min = b.found ? 10'(yl) : 10'd0;
        b.y_max = b.found ? 10'(yh) : 10'd0;
        return b;
    endfunction

    // Leaves vsync low with fall_cyc set to the cycle it dropped.
    task automatic drive_frame(input int gap_pct, input bit junk);
        if (junk) begin
            href = 1'b1;
            for (int i = 0; i < 6; i++) begin
                clken = 1'b1; bit_in = 1'b1; step();
            end
            href = 1'b0; clken = 1'b0; bit_in = 1'b0;
            step(); step();
        end
        vsync = 1'b1;
        step(); step();
        for (int y = 0; y < nlines; y++) begin
            href = 1'b1;
            for (int x = 0; x < line_len[y]; ) begin
                if (int'($urandom_range(99)) < gap_pct) begin
                    clken = 1'b0;
                    bit_in = 1'($urandom_range(1));
                end else begin
                    clken = 1'b1;
                    bit_in = ones.exists(y * 1024 + x) ? 1'b1 : 1'b0;
                    x++;
                end
                step();
            end
            href = 1'b0; clken = 1'b0; bit_in = 1'b0;
            step();
            if ($urandom_range(1) == 1) step();
        end
        vsync = 1'b0;
        fall_cyc = cyc;
    endtask

    task automatic wait_pub(output bit got, output res_t r);
        int w = 0;
        while (res_q.size() == 0 && w < 60) begin
            @(negedge clk);
            w++;
        end
        got = (res_q.size() != 0);
        if (got) r = res_q.pop_front();
    endtask

    task automatic test_reset();
        bit got; res_t r; box_t e1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({a_x_min, a_x_max, a_y_min, a_y_max, a_cnt, a_found, a_done} !== 60'd0) begin
            n_err++; $display("FAIL reset_outputs: got %h required 0",
                {a_x_min, a_x_max, a_y_min, a_y_max, a_cnt, a_found, a_done});
        end
        @(posedge clk); #1; rst_n = 1'b1; step();
        clear_frame(); nlines = 4;
        for (int y = 0; y < 4; y++) line_len[y] = 16;
        ones[1 * 1024 + 3] = 1'b1; ones[2 * 1024 + 9] = 1'b1;
        e1 = model(1);
        drive_frame(0, 1'b0); step();
        wait_pub(got, r);
        n_cmp++;
        if (!got) begin n_err++; $display("FAIL pre_reset_frame: no box_done, required one"); end
        else begin
            n_cmp++;
            if (r.b1 !== e1) begin n_err++; $display("FAIL pre_reset_box: got %h required %h", r.b1, e1); end
        end
        clear_frame(); nlines = 20;
        for (int y = 0; y < 20; y++) line_len[y] = 30;
        for (int y = 2; y < 18; y++) for (int x = 4; x < 20; x++) ones[y * 1024 + x] = 1'b1;
        fork
            drive_frame(10, 1'b0);
            begin
                repeat (100) @(posedge clk);
                #3; rst_n = 1'b0;
                #1;
                n_cmp++;
                if ({a_x_min, a_x_max, a_y_min, a_y_max, a_cnt, a_found, a_done,
                     b_x_min, b_x_max, b_y_min, b_y_max, b_cnt, b_found, b_done} !== 120'd0) begin
                    n_err++; $display("FAIL midframe_reset_clear: got %h / %h required 0",
                        {a_x_min, a_x_max, a_y_min, a_y_max, a_cnt, a_found},
                        {b_x_min, b_x_max, b_y_min, b_y_max, b_cnt, b_found});
                end
                @(posedge clk); #3; rst_n = 1'b1;
            end
        join
        repeat (20) step();
        n_cmp++;
        if (res_q.size() != 0) begin
            n_err++; $display("FAIL reset_frame_dropped: got %0d box_done required 0", res_q.size());
            res_q.delete();
        end
    endtask

    task automatic test_block();
        bit got; res_t r; box_t e64, e1; int fc;
        clear_frame(); nlines = 64;
        for (int y = 0; y < 64; y++) line_len[y] = 120;
        for (int y = 50; y < 58; y++) for (int x = 100; x < 108; x++) ones[y * 1024 + x] = 1'b1;
        e64 = model(64); e1 = model(1);
        drive_frame(20, 1'b1); fc = fall_cyc; step();
        wait_pub(got, r);
        n_cmp++;
        if (!got) begin n_err++; $display("FAIL block_done: got 0 pulses required 1"); return; end
        n_cmp++;
        if (r.cyc - fc !== 2) begin n_err++; $display("FAIL block_latency: got %0d required 2", r.cyc - fc); end
        n_cmp++;
        if (r.b64 !== e64) begin n_err++; $display("FAIL block_box64: got %h required %h", r.b64, e64); end
        n_cmp++;
        if (r.b1 !== e1) begin n_err++; $display("FAIL block_box1: got %h required %h", r.b1, e1); end
        repeat (3) step();
        n_cmp++;
        if (res_q.size() != 0) begin n_err++; $display("FAIL block_single_pulse: got %0d extra", res_q.size()); res_q.delete(); end
    endtask

    task automatic test_corners();
        bit got; res_t r; box_t e64, e1;
        clear_frame(); nlines = 482;
        for (int y = 0; y < 482; y++) line_len[y] = 1;
        line_len[0] = 640; line_len[479] = 640; line_len[480] = 4; line_len[481] = 4;
        ones[0] = 1'b1; ones[479 * 1024 + 639] = 1'b1;
        for (int x = 0; x < 4; x++) begin ones[480 * 1024 + x] = 1'b1; ones[481 * 1024 + x] = 1'b1; end
        e64 = model(64); e1 = model(1);
        drive_frame(0, 1'b0); step();
        wait_pub(got, r);
        n_cmp++;
        if (!got) begin n_err++; $display("FAIL corners_done: got 0 pulses required 1"); return; end
        n_cmp++;
        if (r.b1 !== e1) begin n_err++; $display("FAIL corners_box1: got %h required %h", r.b1, e1); end
        n_cmp++;
        if (r.b64 !== e64) begin n_err++; $display("FAIL corners_box64: got %h required %h", r.b64, e64); end
        clear_frame(); nlines = 6;
        for (int y = 0; y < 6; y++) line_len[y] = 20;
        e64 = model(64); e1 = model(1);
        drive_frame(10, 1'b1); step();
        wait_pub(got, r);
        n_cmp++;
        if (!got) begin n_err++; $display("FAIL empty_done: got 0 pulses required 1"); return; end
        n_cmp++;
        if (r.b1 !== e1 || r.b64 !== e64) begin
            n_err++; $display("FAIL empty_box: got %h/%h required %h/%h", r.b64, r.b1, e64, e1);
        end
    endtask

    task automatic test_scattered_63();
        bit got; res_t r; box_t e64, e1;
        clear_frame(); nlines = 32;
        for (int y = 0; y < 32; y++) line_len[y] = 40;
        while (ones.size() < 63) ones[int'($urandom_range(31)) * 1024 + int'($urandom_range(39))] = 1'b1;
        e64 = model(64); e1 = model(1);
        drive_frame(15, 1'b0); step();
        wait_pub(got, r);
        n_cmp++;
        if (!got) begin n_err++; $display("FAIL s63_done: got 0 pulses required 1"); return; end
        n_cmp++;
        if (r.b64 !== e64) begin n_err++; $display("FAIL s63_box64: got %h required %h", r.b64, e64); end
        n_cmp++;
        if (r.b1 !== e1) begin n_err++; $display("FAIL s63_box1: got %h required %h", r.b1, e1); end
    endtask

    task automatic test_wide_line();
        bit got; res_t r; box_t e64;
        clear_frame(); nlines = 5;
        for (int y = 0; y < 5; y++) line_len[y] = 50;
        line_len[2] = 700;
        for (int x = 0; x < 700; x++) ones[2 * 1024 + x] = 1'b1;
        e64 = model(64);
        drive_frame(15, 1'b0); step();
        wait_pub(got, r);
        n_cmp++;
        if (!got) begin n_err++; $display("FAIL wide_done: got 0 pulses required 1"); return; end
        n_cmp++;
        if (r.b64 !== e64) begin n_err++; $display("FAIL wide_box64: got %h required %h", r.b64, e64); end
    endtask

    task automatic test_random_frames();
        bit got; res_t r; box_t e64, e1; int fc, dens;
        for (int f = 0; f < 5; f++) begin
            clear_frame();
            nlines = 2 + int'($urandom_range(10));
            dens = int'($urandom_range(60));
            for (int y = 0; y < nlines; y++) begin
                line_len[y] = ($urandom_range(7) == 0) ? 650 : 1 + int'($urandom_range(89));
                for (int x = 0; x < line_len[y]; x++)
                    if (int'($urandom_range(99)) < dens) ones[y * 1024 + x] = 1'b1;
            end
            e64 = model(64); e1 = model(1);
            drive_frame(int'($urandom_range(40)), 1'($urandom_range(1))); fc = fall_cyc; step();
            wait_pub(got, r);
            n_cmp++;
            if (!got) begin n_err++; $display("FAIL rand%0d_done: got 0 pulses required 1", f); continue; end
            n_cmp++;
            if (r.cyc - fc !== 2) begin n_err++; $display("FAIL rand%0d_latency: got %0d required 2", f, r.cyc - fc); end
            n_cmp++;
            if (r.b64 !== e64) begin n_err++; $display("FAIL rand%0d_box64: got %h required %h", f, r.b64, e64); end
            n_cmp++;
            if (r.b1 !== e1) begin n_err++; $display("FAIL rand%0d_box1: got %h required %h", f, r.b1, e1); end
            n_cmp++;
            if (r.done1 !== 1'b1) begin n_err++; $display("FAIL rand%0d_done1: got %b required 1", f, r.done1); end
        end
    endtask

    task automatic test_back_to_back();
        bit got; res_t r; box_t e64_1, e1_1, e64_2, e1_2; int fc1, fc2;
        clear_frame(); nlines = 6;
        for (int y = 0; y < 6; y++) line_len[y] = 40;
        for (int y = 1; y < 6; y++) for (int x = 10; x < 25; x++) ones[y * 1024 + x] = 1'b1;
        e64_1 = model(64); e1_1 = model(1);
        drive_frame(30, 1'b0); fc1 = fall_cyc;
        step();
        clear_frame(); nlines = 5;
        for (int y = 0; y < 5; y++) line_len[y] = 30;
        e64_2 = model(64); e1_2 = model(1);
        drive_frame(30, 1'b0); fc2 = fall_cyc; step();
        wait_pub(got, r);
        n_cmp++;
        if (!got) begin n_err++; $display("FAIL b2b_f1_done: got 0 pulses required 1"); return; end
        n_cmp++;
        if (r.cyc - fc1 !== 2) begin n_err++; $display("FAIL b2b_f1_latency: got %0d required 2", r.cyc - fc1); end
        n_cmp++;
        if (r.b64 !== e64_1 || r.b1 !== e1_1) begin
            n_err++; $display("FAIL b2b_f1_box: got %h/%h required %h/%h", r.b64, r.b1, e64_1, e1_1);
        end
        wait_pub(got, r);
        n_cmp++;
        if (!got) begin n_err++; $display("FAIL b2b_f2_done: got 0 pulses required 1"); return; end
        n_cmp++;
        if (r.cyc - fc2 !== 2) begin n_err++; $display("FAIL b2b_f2_latency: got %0d required 2", r.cyc - fc2); end
        n_cmp++;
        if (r.b64 !== e64_2 || r.b1 !== e1_2) begin
            n_err++; $display("FAIL b2b_f2_box: got %h/%h required %h/%h", r.b64, r.b1, e64_2, e1_2);
        end
    endtask

    initial begin
        test_reset();
        test_block();
        test_corners();
        test_scattered_63();
        test_wide_line();
        test_random_frames();
        test_back_to_back();
        repeat (3) step();
        n_cmp++;
        if (stray != 0) begin n_err++; $display("FAIL done_alignment: got %0d unmatched pulses required 0", stray); end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
